// File: rtl/neuron_seq.sv
// Neuron sequencer: clears the MAC, streams input/weight byte pairs from two RAMs into it,
// then looks up the saturated accumulator in the activation LUT and returns one byte with a done pulse.
module neuron_seq #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        in_rdata,
  input  logic [7:0]        wt_rdata,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  output logic              mac_clr_n,
  input  logic [10:0]       mac_addr_lut,
  output logic [10:0]       lut_addr,
  output logic              lut_rd_en,
  input  logic [7:0]        lut_rdata,
  output logic [7:0]        result,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_LUT  = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  // Handshake: start is a one-cycle request honoured only in IDLE; done is a one-cycle
  // pulse with result valid in the same cycle, and result holds until the next done.
  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_valid;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [10:0]        r_lut_addr;
  logic [7:0]         r_result;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_addr;

  assign w_len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CLR;
      S_CLR:  w_next = (r_len != '0) ? S_ACC : S_LUT;
      S_ACC:  if (r_cnt == r_len - LEN_W'(1)) w_next = S_LUT;
      S_LUT:  w_next = S_WAIT;
      S_WAIT: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read issue: address 0 goes out during CLR, the rest while ACC still has unissued pairs.
  always_comb begin
    w_rd_en = 1'b0;
    w_addr  = r_mem_addr;
    case (r_state)
      S_CLR: begin
        w_rd_en = (r_len != '0);
        w_addr  = '0;
      end
      S_ACC: begin
        if (r_idx < r_len) begin
          w_rd_en = 1'b1;
          w_addr  = r_idx[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_mem_addr <= '0;
      r_lut_addr <= '0;
      r_result   <= '0;
    end else begin
      r_valid <= w_rd_en;
      if (w_rd_en) r_mem_addr <= w_addr;
      case (r_state)
        S_IDLE: if (start) r_len <= w_len_clamped;
        S_CLR: begin
          r_idx <= (r_len != '0) ? LEN_W'(1) : '0;
          r_cnt <= '0;
        end
        S_ACC: begin
          if (w_rd_en) r_idx <= r_idx + LEN_W'(1);
          r_cnt <= r_cnt + LEN_W'(1);
        end
        S_LUT:  r_lut_addr <= mac_addr_lut;
        S_WAIT: r_result   <= lut_rdata;
        default: ;
      endcase
    end
  end

  // RAM data reaches the MAC only in cycles that carry a real pair, so idle cycles add zero.
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    mac_clr_n = (r_state != S_CLR);
    lut_rd_en = (r_state == S_LUT);
    lut_addr  = (r_state == S_LUT) ? mac_addr_lut : r_lut_addr;
    mem_rd_en = w_rd_en;
    mem_addr  = w_addr;
    mac_a     = r_valid ? in_rdata : 8'h00;
    mac_b     = r_valid ? wt_rdata : 8'h00;
    result    = r_result;
    dbg_state = r_state;
  end

endmodule
